// File: rtl/inst_chk_pkg.sv
// Shared decode constants and sequencing state for the instruction-stream constraint.
package inst_chk_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_NOP    = 7'h7F;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;
    localparam logic [6:0] F7_MULDIV  = 7'h01;

    typedef enum logic [1:0] {
        ST_PRE   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CHECK = 2'd2
    } seq_state_e;

    // funct3 010/011 have no branch encoding in RV32I
    function automatic logic is_branch_funct3(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

endpackage

// File: rtl/inst_seq_constraint_if.sv
// Fetch-side bundle plus constraint/status outputs of the instruction-stream constraint.
interface inst_seq_constraint_if #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DRAIN_CYCLES = 16
);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    logic [FETCH_WIDTH*32-1:0] inst_i;
    logic [FETCH_WIDTH-1:0]    inst_valid_i;
    logic                      fetch_stall_i;
    logic                      sit_trigger_i;

    logic                      constraint_ok;
    logic [FETCH_WIDTH-1:0]    slot_legal_o;
    logic [1:0]                state_o;
    logic [31:0]               sit_inst_o;
    logic [1:0]                sit_slot_o;
    logic [DCW-1:0]            drain_cnt_o;
    logic                      check_window_o;

    modport master (
        output inst_i, inst_valid_i, fetch_stall_i, sit_trigger_i,
        input  constraint_ok, slot_legal_o, state_o, sit_inst_o, sit_slot_o,
               drain_cnt_o, check_window_o
    );

    modport slave (
        input  inst_i, inst_valid_i, fetch_stall_i, sit_trigger_i,
        output constraint_ok, slot_legal_o, state_o, sit_inst_o, sit_slot_o,
               drain_cnt_o, check_window_o
    );

endinterface

// File: rtl/inst_legal_decode.sv
// Combinational legality check of one 32-bit instruction against the RV32IM subset.
module inst_legal_decode
    import inst_chk_pkg::*;
#(
    parameter bit QED_MODE  = 1'b0,
    parameter bit ALLOW_MUL = 1'b1,
    parameter bit ALLOW_MEM = 1'b1
) (
    input  logic [31:0] inst,
    output logic        legal,
    output logic        is_nop
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regs_i_ok;
    logic       regs_r_ok;
    logic       mem_addr_ok;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // QED mode keeps ALU traffic in x0..x15 and memory at small absolute addresses
    assign regs_i_ok   = !QED_MODE || ((rd < 5'd16) && (rs1 < 5'd16));
    assign regs_r_ok   = regs_i_ok && (!QED_MODE || (rs2 < 5'd16));
    assign mem_addr_ok = !QED_MODE || ((rs1 == 5'd0) && (inst[31:30] == 2'b00));

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE:   legal = regs_r_ok;
                    F7_ALT:    legal = regs_r_ok && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR));
                    F7_MULDIV: legal = ALLOW_MUL && regs_r_ok && !funct3[2];
                    default:   legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_SLL:  legal = regs_i_ok && (funct7 == F7_BASE);
                    F3_SR:   legal = regs_i_ok && ((funct7 == F7_BASE) || (funct7 == F7_ALT));
                    default: legal = regs_i_ok;
                endcase
            end
            OPC_LOAD, OPC_STORE: legal = ALLOW_MEM && (funct3 == F3_WORD) && mem_addr_ok;
            OPC_JAL:             legal = 1'b1;
            OPC_JALR:            legal = (funct3 == F3_JALR);
            OPC_BRANCH:          legal = is_branch_funct3(funct3);
            OPC_NOP:             legal = 1'b1;
            default:             legal = 1'b0;
        endcase
    end

    assign is_nop = (opcode == OPC_NOP);

endmodule

// File: rtl/inst_seq_constraint.sv
// Instruction-stream constraint for formal runs: legal pre-phase, one captured SIT,
// NOP-only drain, then a terminal check window.
//   state    | meaning
//   ST_PRE   | any legal instructions; waits for the SIT trigger
//   ST_DRAIN | SIT captured; only NOPs, counting accepted bundles
//   ST_CHECK | drain complete; NOP-only, check window open until reset
module inst_seq_constraint
    import inst_chk_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int PRE_MAX      = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter bit QED_MODE     = 1'b0,
    parameter bit ALLOW_MUL    = 1'b1,
    parameter bit ALLOW_MEM    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_seq_constraint_if.slave bus
);

    localparam int PCW = $clog2(PRE_MAX + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [PCW-1:0] PRE_LIMIT  = PCW'(PRE_MAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    seq_state_e                state_q, state_d;
    logic [PCW-1:0]            pre_cnt_q, pre_cnt_d;
    logic [DCW-1:0]            drain_cnt_q, drain_cnt_d;
    logic [31:0]               sit_inst_q, sit_inst_d;
    logic [1:0]                sit_slot_q, sit_slot_d;

    logic                      stall_q;
    logic [FETCH_WIDTH*32-1:0] inst_q;
    logic [FETCH_WIDTH-1:0]    valid_q;

    logic [FETCH_WIDTH-1:0]    slot_legal;
    logic [FETCH_WIDTH-1:0]    slot_nop;
    logic                      accept;
    logic                      hold_ok;
    logic                      slots_ok;
    logic                      forced_ok;

    logic                      sit_found;
    logic                      sit_multi;
    logic [1:0]                sit_idx;
    logic [31:0]               sit_word;

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
        inst_legal_decode #(
            .QED_MODE  (QED_MODE),
            .ALLOW_MUL (ALLOW_MUL),
            .ALLOW_MEM (ALLOW_MEM)
        ) u_decode (
            .inst   (bus.inst_i[32*k +: 32]),
            .legal  (slot_legal[k]),
            .is_nop (slot_nop[k])
        );
    end

    assign accept = !bus.fetch_stall_i && (|bus.inst_valid_i);

    // A stalled bundle must be re-presented unchanged on the following cycle
    assign hold_ok = !stall_q ||
                     ((bus.inst_i == inst_q) && (bus.inst_valid_i == valid_q));

    always_comb begin
        sit_found = 1'b0;
        sit_multi = 1'b0;
        sit_idx   = 2'd0;
        sit_word  = 32'd0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (bus.inst_valid_i[k] && !slot_nop[k]) begin
                if (sit_found) begin
                    sit_multi = 1'b1;
                end else begin
                    sit_idx  = 2'(k);
                    sit_word = bus.inst_i[32*k +: 32];
                end
                sit_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        drain_cnt_d = drain_cnt_q;
        sit_inst_d  = sit_inst_q;
        sit_slot_d  = sit_slot_q;
        slots_ok    = 1'b1;
        forced_ok   = 1'b1;
        case (state_q)
            ST_PRE: begin
                slots_ok = !(|(bus.inst_valid_i & ~slot_legal));
                if (accept && (pre_cnt_q == PRE_LIMIT) && !bus.sit_trigger_i) begin
                    forced_ok = 1'b0;
                end
                if (accept) begin
                    if (bus.sit_trigger_i && sit_found) begin
                        // everything after the SIT in the same bundle must be filler
                        if (sit_multi) begin
                            slots_ok = 1'b0;
                        end
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                        sit_inst_d  = sit_word;
                        sit_slot_d  = sit_idx;
                    end else if (pre_cnt_q != PRE_LIMIT) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                slots_ok = !(|(bus.inst_valid_i & ~slot_nop));
                if (accept) begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                slots_ok = !(|(bus.inst_valid_i & ~slot_nop));
            end
            default: begin
                state_d = ST_PRE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PRE;
            pre_cnt_q   <= '0;
            drain_cnt_q <= '0;
            sit_inst_q  <= '0;
            sit_slot_q  <= '0;
            stall_q     <= 1'b0;
            inst_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            sit_inst_q  <= sit_inst_d;
            sit_slot_q  <= sit_slot_d;
            stall_q     <= bus.fetch_stall_i;
            inst_q      <= bus.inst_i;
            valid_q     <= bus.inst_valid_i;
        end
    end

    assign bus.constraint_ok  = slots_ok && forced_ok && hold_ok;
    assign bus.slot_legal_o   = slot_legal;
    assign bus.state_o        = state_q;
    assign bus.sit_inst_o     = sit_inst_q;
    assign bus.sit_slot_o     = sit_slot_q;
    assign bus.drain_cnt_o    = drain_cnt_q;
    assign bus.check_window_o = (state_q == ST_CHECK);

endmodule

// File: tb/tb_inst_seq_constraint.sv
// Two constraint instances (permissive and QED/restricted) fed the same directed and
// random fetch stream, each compared against a behavioural model every cycle.
module tb_inst_seq_constraint;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADD17 = 32'h003108B3;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_NOP   = 32'h0000007F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_seq_constraint_if #(.FETCH_WIDTH(2), .DRAIN_CYCLES(16)) ifa ();
    inst_seq_constraint_if #(.FETCH_WIDTH(2), .DRAIN_CYCLES(3))  ifb ();

    inst_seq_constraint #(
        .FETCH_WIDTH(2), .PRE_MAX(8), .DRAIN_CYCLES(16),
        .QED_MODE(1'b0), .ALLOW_MUL(1'b1), .ALLOW_MEM(1'b1)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    inst_seq_constraint #(
        .FETCH_WIDTH(2), .PRE_MAX(2), .DRAIN_CYCLES(3),
        .QED_MODE(1'b1), .ALLOW_MUL(1'b0), .ALLOW_MEM(1'b0)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model configuration and state, index 0 = dut_a, 1 = dut_b
    int cfg_pre_max [2] = '{8, 2};
    int cfg_drain   [2] = '{16, 3};
    bit cfg_qed     [2] = '{1'b0, 1'b1};
    bit cfg_mul     [2] = '{1'b1, 1'b0};
    bit cfg_mem     [2] = '{1'b1, 1'b0};

    int          m_phase [2];
    int          m_pre   [2];
    int          m_drain [2];
    int          m_slot  [2];
    logic [31:0] m_sit   [2];

    bit          prev_stall;
    logic [63:0] prev_inst;
    logic [1:0]  prev_valid;

    logic [31:0] cur_s0, cur_s1;
    logic [1:0]  cur_v;
    bit          cur_st, cur_tr;

    function automatic bit model_legal(input logic [31:0] x, input bit qed, input bit mul, input bit mem);
        int op  = int'(x[6:0]);
        int rd  = int'(x[11:7]);
        int f3  = int'(x[14:12]);
        int rs1 = int'(x[19:15]);
        int rs2 = int'(x[24:20]);
        int f7  = int'(x[31:25]);
        bit ok  = 1'b0;
        if (op == 'h33) begin
            ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) || (mul && f7 == 1 && f3 < 4);
            if (qed && (rd >= 16 || rs1 >= 16 || rs2 >= 16)) ok = 1'b0;
        end else if (op == 'h13) begin
            if (f3 == 1)      ok = (f7 == 0);
            else if (f3 == 5) ok = (f7 == 0 || f7 == 'h20);
            else              ok = 1'b1;
            if (qed && (rd >= 16 || rs1 >= 16)) ok = 1'b0;
        end else if (op == 'h03 || op == 'h23) begin
            ok = mem && f3 == 2;
            if (qed && (rs1 != 0 || x[31:30] != 2'b00)) ok = 1'b0;
        end else if (op == 'h6F || op == 'h7F) begin
            ok = 1'b1;
        end else if (op == 'h67) begin
            ok = (f3 == 0);
        end else if (op == 'h63) begin
            ok = (f3 != 2 && f3 != 3);
        end
        return ok;
    endfunction

    task automatic model_check(input int d, input logic ok_o, input logic [1:0] legal_o,
                               input logic [1:0] state_o, input logic [31:0] sit_o,
                               input logic [1:0] slot_o, input int drain_o, input logic win_o);
        logic [31:0] w [2];
        bit          lg [2];
        bit          np [2];
        int          nonnop [$];
        bit          accept;
        bit          ok;
        string       p;
        p      = (d == 0) ? "a" : "b";
        w[0]   = cur_s0;
        w[1]   = cur_s1;
        accept = !cur_st && (cur_v != 2'b00);
        ok     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lg[k] = model_legal(w[k], cfg_qed[d], cfg_mul[d], cfg_mem[d]);
            np[k] = (w[k][6:0] == 7'h7F);
            if (cur_v[k] && !np[k]) nonnop.push_back(k);
        end
        if (prev_stall && ({cur_s1, cur_s0} != prev_inst || cur_v != prev_valid)) ok = 1'b0;
        if (m_phase[d] == 0) begin
            for (int k = 0; k < 2; k++) if (cur_v[k] && !lg[k]) ok = 1'b0;
            if (accept && m_pre[d] == cfg_pre_max[d] && !cur_tr) ok = 1'b0;
            if (accept && cur_tr && nonnop.size() > 1) ok = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) if (cur_v[k] && !np[k]) ok = 1'b0;
        end
        chk({p, "_ok"},     ok_o,    ok);
        chk({p, "_legal"},  legal_o, {lg[1], lg[0]});
        chk({p, "_state"},  state_o, m_phase[d]);
        chk({p, "_sit"},    sit_o,   m_sit[d]);
        chk({p, "_slot"},   slot_o,  m_slot[d]);
        chk({p, "_drain"},  drain_o, m_drain[d]);
        chk({p, "_window"}, win_o,   m_phase[d] == 2);
        if (accept) begin
            if (m_phase[d] == 0) begin
                if (cur_tr && nonnop.size() > 0) begin
                    m_phase[d] = 1;
                    m_drain[d] = 0;
                    m_sit[d]   = w[nonnop[0]];
                    m_slot[d]  = nonnop[0];
                end else if (m_pre[d] < cfg_pre_max[d]) begin
                    m_pre[d]++;
                end
            end else if (m_phase[d] == 1) begin
                m_drain[d]++;
                if (m_drain[d] == cfg_drain[d]) m_phase[d] = 2;
            end
        end
    endtask

    task automatic drive();
        ifa.inst_i = {cur_s1, cur_s0}; ifa.inst_valid_i = cur_v;
        ifa.fetch_stall_i = cur_st;    ifa.sit_trigger_i = cur_tr;
        ifb.inst_i = {cur_s1, cur_s0}; ifb.inst_valid_i = cur_v;
        ifb.fetch_stall_i = cur_st;    ifb.sit_trigger_i = cur_tr;
    endtask

    task automatic step(input logic [31:0] s0, input logic [31:0] s1, input logic [1:0] v,
                        input bit st, input bit tr);
        @(negedge clk);
        cur_s0 = s0; cur_s1 = s1; cur_v = v; cur_st = st; cur_tr = tr;
        drive();
        #1;
        model_check(0, ifa.constraint_ok, ifa.slot_legal_o, ifa.state_o, ifa.sit_inst_o,
                    ifa.sit_slot_o, int'(ifa.drain_cnt_o), ifa.check_window_o);
        model_check(1, ifb.constraint_ok, ifb.slot_legal_o, ifb.state_o, ifb.sit_inst_o,
                    ifb.sit_slot_o, int'(ifb.drain_cnt_o), ifb.check_window_o);
        prev_stall = st;
        prev_inst  = {s1, s0};
        prev_valid = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_a_state",  ifa.state_o,        0);
        chk("rst_a_drain",  ifa.drain_cnt_o,    0);
        chk("rst_a_window", ifa.check_window_o, 0);
        chk("rst_a_sit",    ifa.sit_inst_o,     0);
        chk("rst_b_state",  ifb.state_o,        0);
        chk("rst_b_drain",  ifb.drain_cnt_o,    0);
        chk("rst_b_slot",   ifb.sit_slot_o,     0);
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_pre[d] = 0; m_drain[d] = 0; m_slot[d] = 0; m_sit[d] = '0;
        end
        prev_stall = 1'b0; prev_inst = '0; prev_valid = '0;
        cur_s0 = '0; cur_s1 = '0; cur_v = '0; cur_st = 1'b0; cur_tr = 1'b0;
        drive();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rd  = 5'($urandom);
        logic [4:0] rs1 = 5'($urandom);
        logic [4:0] rs2 = 5'($urandom);
        logic [2:0] f3  = 3'($urandom);
        logic [6:0] f7  = 7'($urandom);
        case ($urandom_range(0, 9))
            0, 1: return {25'($urandom), 7'h7F};
            2: begin
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: ;
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            3: begin
                if ($urandom_range(0, 2) != 0) f7 = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
                return {f7, rs2, rs1, f3, rd, 7'h13};
            end
            4: return {f7, rs2, rs1, ($urandom_range(0, 3) != 0) ? 3'b010 : f3, rd,
                       ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h23};
            5: begin
                case ($urandom_range(0, 2))
                    0: return {f7, rs2, rs1, f3, rd, 7'h6F};
                    1: return {f7, rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'b000 : f3, rd, 7'h67};
                    default: return {f7, rs2, rs1, f3, rd, 7'h63};
                endcase
            end
            6: return $urandom;
            7: return {7'h00, 1'b0, rs2[3:0], 1'b0, rs1[3:0], f3, 1'b0, rd[3:0], 7'h33};
            8: return {7'h01, 1'b0, rs2[3:0], 1'b0, rs1[3:0], 1'b0, f3[1:0], 1'b0, rd[3:0], 7'h33};
            default: return {2'b00, 10'($urandom), 5'd0, 3'b010, rd, 7'h03};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        cur_s0 = '0; cur_s1 = '0; cur_v = '0; cur_st = 1'b0; cur_tr = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // SIT capture from slot 0 of an ADD+NOP bundle
        do_reset();
        step(I_ADD, I_NOP, 2'b11, 1'b0, 1'b1);
        chk("t1_ok_a", ifa.constraint_ok, 1);
        @(posedge clk); #1;
        chk("t1_state_a", ifa.state_o, 1);
        chk("t1_sit_a",   ifa.sit_inst_o, I_ADD);
        chk("t1_slot_a",  ifa.sit_slot_o, 0);

        // x17 destination only rejected under QED
        do_reset();
        step(I_ADD17, I_NOP, 2'b01, 1'b0, 1'b0);
        chk("t2_legal_b", ifb.slot_legal_o[0], 0);
        chk("t2_ok_b",    ifb.constraint_ok, 0);
        chk("t2_ok_a",    ifa.constraint_ok, 1);

        // MUL rejected only when in a valid slot of the no-MUL instance
        do_reset();
        step(I_MUL, I_NOP, 2'b01, 1'b0, 1'b0);
        chk("t3_ok_b", ifb.constraint_ok, 0);
        chk("t3_ok_a", ifa.constraint_ok, 1);
        step(I_MUL, I_NOP, 2'b10, 1'b0, 1'b0);
        chk("t3_inv_ok_b", ifb.constraint_ok, 1);

        // forced trigger once PRE_MAX bundles have been accepted
        do_reset();
        step(I_ADD, I_NOP, 2'b01, 1'b0, 1'b0);
        step(I_ADD, I_NOP, 2'b01, 1'b0, 1'b0);
        step(I_ADD, I_NOP, 2'b01, 1'b0, 1'b0);
        chk("t4_forced_b", ifb.constraint_ok, 0);
        chk("t4_ok_a",     ifa.constraint_ok, 1);
        step(I_ADD, I_NOP, 2'b01, 1'b0, 1'b1);
        chk("t4_trig_ok_b", ifb.constraint_ok, 1);
        @(posedge clk); #1;
        chk("t4_state_b", ifb.state_o, 1);

        // drain of three accepts with two stalls in between
        step(I_NOP, I_NOP, 2'b11, 1'b0, 1'b0);
        step(I_NOP, I_NOP, 2'b11, 1'b1, 1'b0);
        step(I_NOP, I_NOP, 2'b11, 1'b1, 1'b0);
        chk("t5_hold_ok_b", ifb.constraint_ok, 1);
        step(I_NOP, I_NOP, 2'b11, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t5_win_early_b", ifb.check_window_o, 0);
        chk("t5_drain2_b",    ifb.drain_cnt_o, 2);
        step(I_ADD, I_NOP, 2'b01, 1'b0, 1'b0);
        chk("t5_add_b", ifb.constraint_ok, 0);
        chk("t5_add_a", ifa.constraint_ok, 0);
        @(posedge clk); #1;
        chk("t5_win_b",    ifb.check_window_o, 1);
        chk("t5_state_b",  ifb.state_o, 2);
        chk("t5_drain3_b", ifb.drain_cnt_o, 3);

        // hold violation, then reset while dut_a is mid-drain
        step(I_NOP, I_NOP, 2'b01, 1'b1, 1'b0);
        step(32'h0000107F, I_NOP, 2'b01, 1'b1, 1'b0);
        chk("t6_hold_a", ifa.constraint_ok, 0);
        chk("t6_hold_b", ifb.constraint_ok, 0);
        chk("t6_pre_rst_a", ifa.state_o, 1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            if (prev_stall && $urandom_range(0, 7) != 0)
                step(cur_s0, cur_s1, cur_v, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            else
                step(rand_inst(), rand_inst(), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
